mips_mc_control: RTL

Multi-cycle main controller that sequences the MIPS datapath one phase per clock, replacing the single-cycle combinational decode. It latches the opcode presented by the datapath and walks it through FETCH/DECODE/EXEC/MEM/WB states. In each state it drives the datapath control strobes: RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch and ALUOp, plus PCWrite and IRWrite. It waits on a data-memory ready handshake, counts retired instructions, and flags illegal opcodes.

---
 rtl/mips_ctrl_pkg.sv | 59 +++++
 rtl/mips_mc_control_if.sv | 33 +++
 rtl/mips_ctrl_decode.sv | 63 ++++++
 rtl/mips_mc_control.sv | 73 +++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALUOp codes, FSM state encoding and control-strobe bundle for the
// multi-cycle MIPS controller. JUMP_EN adds the JUMP state and the j opcode.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_MEM_RD = 4'd3,
      S_MEM_WR = 4'd4,
      S_WB_ALU = 4'd5,
      S_WB_MEM = 4'd6,
`ifdef JUMP_EN
      S_BRANCH = 4'd7,
      S_JUMP   = 4'd8
`else
      S_BRANCH = 4'd7
`endif
   } state_t;

   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
      logic       jump;
      logic       retire;
   } ctrl_t;

   // State that follows DECODE; S_FETCH means the opcode is unsupported.
   function automatic state_t decode_next(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_ADDI: return S_EXEC;
         OP_BEQ:                          return S_BRANCH;
`ifdef JUMP_EN
         OP_J:                            return S_JUMP;
`endif
         default:                         return S_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Controller <-> datapath bundle: opcode, run enable, memory handshake in; strobes,
// retire pulse, sticky illegal flag and retired-instruction count out.
interface mips_mc_control_if #(parameter int COUNT_W = 32);
   logic               en;
   logic [5:0]         OpCode;
   logic               mem_ready;
   logic               RegDst;
   logic               AluSrc;
   logic               MemtoReg;
   logic               RegWrite;
   logic               MemRead;
   logic               MemWrite;
   logic               Branch;
   logic [1:0]         ALUOp;
   logic               PCWrite;
   logic               IRWrite;
   logic               Jump;
   logic               retire;
   logic               illegal;
   logic [COUNT_W-1:0] instr_count;

   modport master (
      input  en, OpCode, mem_ready,
      output RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
             PCWrite, IRWrite, Jump, retire, illegal, instr_count
   );

   modport slave (
      output en, OpCode, mem_ready,
      input  RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
             PCWrite, IRWrite, Jump, retire, illegal, instr_count
   );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational strobe decode from (state, op_q); en and mem_ready only qualify the
// FETCH and MEM_WR strobes.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] op_q,
   input  logic       en,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      // NOTE: default every field first so no path through the case leaves a latch.
      ctrl = '0;
      unique case (state)
         S_FETCH: begin
            ctrl.ir_write = en;
            ctrl.pc_write = en;
         end
         S_DECODE: ;
         S_EXEC: begin
            ctrl.alu_src = (op_q != OP_RTYPE);
            ctrl.alu_op  = (op_q == OP_RTYPE) ? ALUOP_FUNCT : ALUOP_ADD;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.alu_src  = 1'b1;
            ctrl.alu_op   = ALUOP_ADD;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.retire    = mem_ready;
         end
         S_WB_ALU: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = (op_q == OP_RTYPE);
            ctrl.retire    = 1'b1;
         end
         S_WB_MEM: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.retire     = 1'b1;
         end
         S_BRANCH: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALUOP_SUB;
            ctrl.retire = 1'b1;
         end
`ifdef JUMP_EN
         S_JUMP: begin
            ctrl.jump     = 1'b1;
            ctrl.pc_write = 1'b1;
            ctrl.retire   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main controller: state register, latched opcode, sticky illegal flag,
// retired-instruction counter and reset gating of all outputs. Optional macro: JUMP_EN.
module mips_mc_control
   import mips_ctrl_pkg::*;
#(
   parameter int COUNT_W = 32
) (
   input logic                clk,
   input logic                reset,
   mips_mc_control_if.master  bus
);

   state_t             state;
   logic [5:0]         op_q;
   logic               illegal_q;
   logic [COUNT_W-1:0] count_q;
   ctrl_t              ctrl;

   mips_ctrl_decode u_decode (
      .state     (state),
      .op_q      (op_q),
      .en        (bus.en),
      .mem_ready (bus.mem_ready),
      .ctrl      (ctrl)
   );

   // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_FETCH;
         op_q      <= '0;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         if (ctrl.retire) count_q <= count_q + COUNT_W'(1);
         unique case (state)
            S_FETCH:  if (bus.en) state <= S_DECODE;
            S_DECODE: begin
               op_q  <= bus.OpCode;
               state <= decode_next(bus.OpCode);
               if (decode_next(bus.OpCode) == S_FETCH) illegal_q <= 1'b1;
            end
            S_EXEC: begin
               case (op_q)
                  OP_LW:   state <= S_MEM_RD;
                  OP_SW:   state <= S_MEM_WR;
                  default: state <= S_WB_ALU;
               endcase
            end
            S_MEM_RD: if (bus.mem_ready) state <= S_WB_MEM;
            S_MEM_WR: if (bus.mem_ready) state <= S_FETCH;
            default:  state <= S_FETCH;
         endcase
      end
   end

   // Reset is synchronous, so the outputs are gated while it is held low.
   assign bus.IRWrite     = reset & ctrl.ir_write;
   assign bus.PCWrite     = reset & ctrl.pc_write;
   assign bus.RegDst      = reset & ctrl.reg_dst;
   assign bus.AluSrc      = reset & ctrl.alu_src;
   assign bus.MemtoReg    = reset & ctrl.mem_to_reg;
   assign bus.RegWrite    = reset & ctrl.reg_write;
   assign bus.MemRead     = reset & ctrl.mem_read;
   assign bus.MemWrite    = reset & ctrl.mem_write;
   assign bus.Branch      = reset & ctrl.branch;
   assign bus.ALUOp       = reset ? ctrl.alu_op : 2'b00;
   assign bus.Jump        = reset & ctrl.jump;
   assign bus.retire      = reset & ctrl.retire;
   assign bus.illegal     = reset & illegal_q;
   assign bus.instr_count = reset ? count_q : '0;

endmodule
